addr_gen_rs_mp: RTL

// Multi-issue, age-ordered address-generation reservation station for loads/stores. Holds dispatched

---
 rtl/addr_gen_rs_mp.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/addr_gen_rs_mp.sv
// Age-ordered reservation station for load/store address generation.
// Issues up to NUM_AGU ready ops per cycle, oldest first, with branch-mask tracking.
module addr_gen_rs_mp #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned NUM_AGU = 2,
  parameter int unsigned NUM_CDB = 4,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned BR_TAGS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic                        alloc_is_store,
  input  logic [2:0]                  alloc_funct3,
  input  logic [31:0]                 alloc_imm,
  input  logic [PREG_W-1:0]           alloc_prs1,
  input  logic                        alloc_prs1_rdy,
  input  logic [IDX_W-1:0]            alloc_lsq_idx,
  input  logic [BR_TAGS-1:0]          alloc_br_mask,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_preg,
  input  logic                        br_valid,
  input  logic [$clog2(BR_TAGS)-1:0]  br_tag,
  input  logic                        br_mispredict,
  output logic [NUM_AGU*PREG_W-1:0]   prf_raddr,
  input  logic [NUM_AGU*32-1:0]       prf_rdata,
  output logic [NUM_AGU-1:0]          agu_valid,
  output logic [NUM_AGU-1:0]          agu_is_store,
  output logic [NUM_AGU*IDX_W-1:0]    agu_idx,
  output logic [NUM_AGU*3-1:0]        agu_funct3,
  output logic [NUM_AGU*32-1:0]       agu_addr,
  output logic [NUM_AGU*4-1:0]        agu_mask,
  output logic [NUM_AGU-1:0]          agu_misalign,
  output logic [NUM_AGU*BR_TAGS-1:0]  agu_br_mask,
  output logic [$clog2(ENTRIES):0]    occupancy
);

  localparam int unsigned EIDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W  = EIDX_W + 1;

  typedef struct packed {
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic [PREG_W-1:0] prs1;
    logic [IDX_W-1:0]  lsq_idx;
  } entry_t;

  entry_t             ent         [ENTRIES];
  logic [BR_TAGS-1:0] ent_br_mask [ENTRIES];
  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_rdy;
  // older[j][i] set means entry j was allocated before entry i
  logic [ENTRIES-1:0] older       [ENTRIES];

  logic [BR_TAGS-1:0] tag_onehot;
  logic [BR_TAGS-1:0] clr_mask;
  logic               kill;
  logic [ENTRIES-1:0] squash;
  logic [ENTRIES-1:0] elig;
  logic [ENTRIES-1:0] issued;
  logic [ENTRIES-1:0] wake;
  logic [ENTRIES-1:0] valid_next;
  logic [CNT_W-1:0]   occ_next;
  logic [CNT_W-1:0]   rank    [ENTRIES];
  logic [NUM_AGU-1:0] sel_v;
  logic [EIDX_W-1:0]  sel_idx [NUM_AGU];
  logic [31:0]        addr_c  [NUM_AGU];
  logic [4:0]         mm_c    [NUM_AGU];
  logic [EIDX_W-1:0]  free_idx;
  logic               alloc_fire;
  logic               alloc_keep;
  logic               alloc_hit;

  // Operand is available from a same-cycle broadcast; preg 0 is always available
  function automatic logic cdb_hit(input logic [PREG_W-1:0] preg);
    logic hit;
    hit = (preg == '0);
    for (int k = 0; k < int'(NUM_CDB); k++)
      if (cdb_valid[k] && (cdb_preg[k*PREG_W +: PREG_W] == preg)) hit = 1'b1;
    return hit;
  endfunction

  // Returns {misalign, byte_mask}; illegal funct3 gives an empty mask flagged misaligned
  function automatic logic [4:0] mask_mis(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic [4:0] r;
    logic       bad;
    bad = (f3[1:0] == 2'b11) || (f3[2] && (is_store || f3[1]));
    r   = 5'b1_0000;
    if (!bad) begin
      case (f3[1:0])
        2'b00:   r = {1'b0, 4'b0001 << a};
        2'b01:   r = {a[0], 4'b0011 << a};
        2'b10:   r = {(a != 2'b00), 4'b1111};
        default: r = 5'b1_0000;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    tag_onehot = BR_TAGS'(1) << br_tag;
    kill       = br_valid && br_mispredict;
    clr_mask   = (br_valid && !br_mispredict) ? tag_onehot : '0;

    for (int i = 0; i < int'(ENTRIES); i++) begin
      squash[i] = ent_valid[i] && kill && ent_br_mask[i][br_tag];
      elig[i]   = ent_valid[i] && ent_rdy[i] && !squash[i];
      wake[i]   = cdb_hit(ent[i].prs1);
    end

    // Rank = number of older eligible entries; port p takes rank p
    for (int i = 0; i < int'(ENTRIES); i++) begin
      rank[i] = '0;
      for (int j = 0; j < int'(ENTRIES); j++)
        if ((j != i) && elig[j] && older[j][i]) rank[i] = rank[i] + CNT_W'(1);
    end

    issued = '0;
    for (int p = 0; p < int'(NUM_AGU); p++) begin
      sel_v[p]   = 1'b0;
      sel_idx[p] = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (elig[i] && (rank[i] == CNT_W'(p))) begin
          sel_v[p]   = 1'b1;
          sel_idx[p] = EIDX_W'(i);
          issued[i]  = 1'b1;
        end
      end
      prf_raddr[p*PREG_W +: PREG_W] = sel_v[p] ? ent[sel_idx[p]].prs1 : '0;
      addr_c[p] = prf_rdata[p*32 +: 32] + ent[sel_idx[p]].imm;
      mm_c[p]   = mask_mis(ent[sel_idx[p]].is_store, ent[sel_idx[p]].funct3, addr_c[p][1:0]);
    end

    free_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--)
      if (!ent_valid[i]) free_idx = EIDX_W'(i);

    alloc_fire = alloc_valid && alloc_ready;
    alloc_keep = alloc_fire && !(kill && alloc_br_mask[br_tag]);
    alloc_hit  = alloc_prs1_rdy || cdb_hit(alloc_prs1);

    valid_next = ent_valid & ~issued & ~squash;
    if (alloc_keep) valid_next[free_idx] = 1'b1;
    occ_next = '0;
    for (int i = 0; i < int'(ENTRIES); i++) occ_next = occ_next + CNT_W'(valid_next[i]);
  end

  // Entry control state: valid, ready, age order, occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid   <= '0;
      ent_rdy     <= '0;
      alloc_ready <= 1'b1;
      occupancy   <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) older[i] <= '0;
    end else begin
      ent_valid   <= valid_next;
      alloc_ready <= ~&valid_next;
      occupancy   <= occ_next;
      for (int i = 0; i < int'(ENTRIES); i++)
        if (ent_valid[i] && wake[i]) ent_rdy[i] <= 1'b1;
      if (alloc_keep) begin
        ent_rdy[free_idx] <= alloc_hit;
        for (int j = 0; j < int'(ENTRIES); j++) begin
          if (EIDX_W'(j) == free_idx) older[j] <= '0;
          else                        older[j][free_idx] <= 1'b1;
        end
      end
    end
  end

  // Entry payload; only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ENTRIES); i++) ent_br_mask[i] <= ent_br_mask[i] & ~clr_mask;
    if (alloc_keep) begin
      ent[free_idx]         <= '{is_store: alloc_is_store, funct3: alloc_funct3, imm: alloc_imm,
                                 prs1: alloc_prs1, lsq_idx: alloc_lsq_idx};
      ent_br_mask[free_idx] <= alloc_br_mask & ~clr_mask;
    end
  end

  // AGU result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      agu_valid    <= '0;
      agu_is_store <= '0;
      agu_idx      <= '0;
      agu_funct3   <= '0;
      agu_addr     <= '0;
      agu_mask     <= '0;
      agu_misalign <= '0;
      agu_br_mask  <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_AGU); p++) begin
        agu_valid[p] <= sel_v[p];
        if (sel_v[p]) begin
          agu_is_store[p]                <= ent[sel_idx[p]].is_store;
          agu_idx[p*IDX_W +: IDX_W]      <= ent[sel_idx[p]].lsq_idx;
          agu_funct3[p*3 +: 3]           <= ent[sel_idx[p]].funct3;
          agu_addr[p*32 +: 32]           <= addr_c[p];
          agu_mask[p*4 +: 4]             <= mm_c[p][3:0];
          agu_misalign[p]                <= mm_c[p][4];
          agu_br_mask[p*BR_TAGS +: BR_TAGS] <= ent_br_mask[sel_idx[p]] & ~clr_mask;
        end else begin
          agu_br_mask[p*BR_TAGS +: BR_TAGS] <= agu_br_mask[p*BR_TAGS +: BR_TAGS] & ~clr_mask;
        end
      end
    end
  end

endmodule
